// File: rtl/systolic_pkg.sv
// Shared types and memory-map constants for the systolic datapath (matmul FSM and result writer).
package systolic_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_WAIT
    } wr_state_e;

    localparam int unsigned MEM_PORT_WIDTH   = 64;
    localparam logic [31:0] WEIGHT_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] INPUT_BASE_ADDR  = 32'h0000_1000;
    localparam logic [31:0] RESULT_BASE_ADDR = 32'h0000_2000;
    // One full row occupies one memory word of MEM_PORT_WIDTH bits.
    localparam logic [31:0] MEM_ADDR_INCR    = 32'd8;

endpackage

// File: rtl/result_row_fifo.sv
// Synchronous FIFO of completed row indices; the row data itself lives in the writer's row buffer.
module result_row_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             empty_o
);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        push_ok = push_i && ((cnt_q != (PW+1)'(Depth)) || pop_ok);
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q <= (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/systolic_result_writer.sv
// Deskews the skewed systolic column stream into rows and writes them to RAM at RESULT_BASE_ADDR.
// Optional build macro RESULT_RELU_EN clamps negative elements to zero on capture.
module systolic_result_writer
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS               = 4,
    parameter int unsigned COLS               = 4,
    parameter int unsigned WORD_SIZE          = 16,
    parameter int unsigned MEM_ACCESS_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      stall_i,
    input  logic [COLS*WORD_SIZE-1:0] matmul_output_i,
    input  logic [COLS-1:0]           output_col_valid_i,
    output logic [31:0]               mem_addr_o,
    output logic                      mem_wr_en_o,
    output logic [MEM_PORT_WIDTH-1:0] mem_wr_data_o,
    output logic                      busy_o,
    output logic                      wr_done_o,
    output logic                      overflow_o
);
    localparam int unsigned CW = $clog2(ROWS) + 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LW = $clog2(MEM_ACCESS_LATENCY) + 1;

    logic [CW-1:0]        col_cnt_q [COLS];
    logic [WORD_SIZE-1:0] row_buf_q [ROWS][COLS];
    logic [CW-1:0]        wr_cnt_q;
    logic [LW-1:0]        wait_cnt_q;
    wr_state_e            wstate_q;
    logic                 busy_q, overflow_q, wr_done_q, mem_wr_en_q;
    logic [31:0]          mem_addr_q;
    logic [MEM_PORT_WIDTH-1:0] mem_wr_data_q;

    logic [COLS-1:0]           cap_en;
    logic                      ovf_set, push, pop, slot_free, retire, fifo_empty, fifo_clr;
    logic [CW-1:0]             pop_idx;
    logic [31:0]               issue_addr;
    logic [MEM_PORT_WIDTH-1:0] issue_data;

    function automatic logic [WORD_SIZE-1:0] store_elem(input logic [WORD_SIZE-1:0] v);
`ifdef RESULT_RELU_EN
        return v[WORD_SIZE-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign fifo_clr = start_i && !busy_q;

    result_row_fifo #(
        .Depth (ROWS),
        .Width (CW)
    ) u_row_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (fifo_clr),
        .push_i      (push),
        .push_data_i (col_cnt_q[COLS-1]),
        .pop_i       (pop),
        .pop_data_o  (pop_idx),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        cap_en  = '0;
        ovf_set = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (busy_q && !stall_i && output_col_valid_i[c]) begin
                if (col_cnt_q[c] == CW'(ROWS)) ovf_set = 1'b1;
                else                           cap_en[c] = 1'b1;
            end
        end
        push = cap_en[COLS-1];

        // The last occupancy cycle of a write may already pop the next row, so
        // back-to-back writes are exactly MEM_ACCESS_LATENCY cycles apart.
        retire    = ((wstate_q == W_ISSUE) && (MEM_ACCESS_LATENCY == 1)) ||
                    ((wstate_q == W_WAIT) && (wait_cnt_q == LW'(1)));
        slot_free = (wstate_q == W_IDLE) || retire;
        pop       = slot_free && !fifo_empty;

        issue_addr = RESULT_BASE_ADDR + 32'(pop_idx) * MEM_ADDR_INCR;
        issue_data = '0;
        for (int c = 0; c < COLS; c++) begin
            issue_data[c*WORD_SIZE +: WORD_SIZE] = row_buf_q[pop_idx[RW-1:0]][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) col_cnt_q[c] <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) row_buf_q[r][c] <= '0;
            end
            wr_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            wstate_q      <= W_IDLE;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            mem_wr_en_q <= pop;
            wr_done_q   <= 1'b0;
            if (pop) begin
                mem_addr_q    <= issue_addr;
                mem_wr_data_q <= issue_data;
            end

            if (start_i && !busy_q) begin
                busy_q     <= 1'b1;
                overflow_q <= 1'b0;
                wr_cnt_q   <= '0;
                for (int c = 0; c < COLS; c++) col_cnt_q[c] <= '0;
            end else begin
                if (ovf_set) overflow_q <= 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    if (cap_en[c]) begin
                        row_buf_q[col_cnt_q[c][RW-1:0]][c] <=
                            store_elem(matmul_output_i[c*WORD_SIZE +: WORD_SIZE]);
                        col_cnt_q[c] <= col_cnt_q[c] + 1'b1;
                    end
                end
            end

            unique case (wstate_q)
                W_IDLE: if (pop) wstate_q <= W_ISSUE;
                W_ISSUE: begin
                    if (MEM_ACCESS_LATENCY == 1) begin
                        wstate_q <= pop ? W_ISSUE : W_IDLE;
                    end else begin
                        wait_cnt_q <= LW'(MEM_ACCESS_LATENCY - 1);
                        wstate_q   <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 1'b1;
                    if (wait_cnt_q == LW'(1)) wstate_q <= pop ? W_ISSUE : W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase

            if (retire) begin
                if (wr_cnt_q == CW'(ROWS - 1)) begin
                    wr_done_q <= 1'b1;
                    busy_q    <= 1'b0;
                    wr_cnt_q  <= '0;
                    for (int c = 0; c < COLS; c++) col_cnt_q[c] <= '0;
                end else begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                end
            end
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign busy_o        = busy_q;
    assign wr_done_o     = wr_done_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Randomized self-checking bench for systolic_result_writer against a queue-based row/timing model.
module tb_systolic_result_writer;
    import systolic_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WS   = 16;
    localparam int LAT  = 2;

    logic                      clk, rst_n, start, stall;
    logic [COLS*WS-1:0]        matmul_output;
    logic [COLS-1:0]           col_valid;
    logic [31:0]               mem_addr;
    logic                      mem_wr_en, busy, wr_done, overflow;
    logic [MEM_PORT_WIDTH-1:0] mem_wr_data;

    systolic_result_writer #(
        .ROWS               (ROWS),
        .COLS               (COLS),
        .WORD_SIZE          (WS),
        .MEM_ACCESS_LATENCY (LAT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start),
        .stall_i            (stall),
        .matmul_output_i    (matmul_output),
        .output_col_valid_i (col_valid),
        .mem_addr_o         (mem_addr),
        .mem_wr_en_o        (mem_wr_en),
        .mem_wr_data_o      (mem_wr_data),
        .busy_o             (busy),
        .wr_done_o          (wr_done),
        .overflow_o         (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [WS-1:0] vals [ROWS+1][COLS];
    int            tc [COLS];

    int                        wr_cyc_q[$];
    logic [31:0]               wr_addr_q[$];
    logic [MEM_PORT_WIDTH-1:0] wr_data_q[$];
    int                        done_cyc_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wr_data);
            end
            if (wr_done) done_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WS-1:0] exp_store(input logic [WS-1:0] v);
`ifdef RESULT_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic set_nominal();
        for (int r = 0; r <= ROWS; r++)
            for (int c = 0; c < COLS; c++) vals[r][c] = WS'(16 * r + c);
        for (int c = 0; c < COLS; c++) tc[c] = c;
    endtask

    task automatic set_random();
        for (int r = 0; r <= ROWS; r++)
            for (int c = 0; c < COLS; c++) vals[r][c] = WS'($urandom);
        tc[0] = $urandom_range(0, 2);
        for (int c = 1; c < COLS; c++) tc[c] = tc[c-1] + $urandom_range(0, 2);
    endtask

    // Drives one start + column stream and checks the resulting writes and completion.
    task automatic run_stream(input int stall_at, input int stall_len, input bit extra0,
                              input int restart_at, input bit do_reset);
        int            step, idx, lim, prev_issue, issue, exp_done;
        int            cnt [COLS];
        logic [WS-1:0] exp_row [ROWS][COLS];
        int            comp_cyc[$];
        int            comp_row[$];
        int            exp_cyc[$];
        logic [31:0]   exp_addr[$];
        logic [MEM_PORT_WIDTH-1:0] exp_data[$];
        logic [MEM_PORT_WIDTH-1:0] d;
        bit            exp_ovf, stalled, did_reset;

        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); done_cyc_q.delete();
        for (int c = 0; c < COLS; c++) cnt[c] = 0;
        exp_ovf = 1'b0;
        did_reset = 1'b0;
        step = 0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int k = 0; k < 40; k++) begin
            if (do_reset && !did_reset && wr_cyc_q.size() == 2 && wr_cyc_q[1] == cyc - 1) begin
                rst_n = 1'b0;
                did_reset = 1'b1;
                col_valid = '0;
                stall = 1'b0;
                #1;
                check_eq("rst_addr", 64'(mem_addr), 64'd0);
                check_eq("rst_wren", 64'(mem_wr_en), 64'd0);
                check_eq("rst_data", 64'(mem_wr_data), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_done", 64'(wr_done), 64'd0);
                check_eq("rst_ovf", 64'(overflow), 64'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (12) @(posedge clk);
                #1;
                check_eq("rst_no_wr", 64'(wr_cyc_q.size()), 64'd2);
                check_eq("rst_no_done", 64'(done_cyc_q.size()), 64'd0);
                check_eq("rst_idle", 64'(busy), 64'd0);
                break;
            end

            stalled = (k >= stall_at) && (k < stall_at + stall_len);
            start = (k == restart_at);
            stall = stalled;
            for (int c = 0; c < COLS; c++) begin
                idx = step - tc[c];
                lim = (c == 0 && extra0) ? ROWS + 1 : ROWS;
                col_valid[c] = (idx >= 0) && (idx < lim);
                matmul_output[c*WS +: WS] = col_valid[c] ? vals[idx][c] : WS'($urandom);
                if (!stalled && col_valid[c]) begin
                    if (cnt[c] < ROWS) begin
                        exp_row[cnt[c]][c] = exp_store(vals[idx][c]);
                        if (c == COLS - 1) begin
                            comp_cyc.push_back(cyc);
                            comp_row.push_back(cnt[c]);
                        end
                        cnt[c]++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
            if (!stalled) step++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        stall = 1'b0;
        col_valid = '0;

        if (do_reset) begin
            check_eq("rst_hit", 64'(did_reset), 64'd1);
            return;
        end

        prev_issue = -1000;
        for (int i = 0; i < comp_cyc.size(); i++) begin
            issue = (comp_cyc[i] + 2 > prev_issue + LAT) ? comp_cyc[i] + 2 : prev_issue + LAT;
            d = '0;
            for (int c = 0; c < COLS; c++) d[c*WS +: WS] = exp_row[comp_row[i]][c];
            exp_cyc.push_back(issue);
            exp_addr.push_back(RESULT_BASE_ADDR + 32'(comp_row[i]) * MEM_ADDR_INCR);
            exp_data.push_back(d);
            prev_issue = issue;
        end
        exp_done = prev_issue + LAT;

        check_eq("n_writes", 64'(wr_cyc_q.size()), 64'(ROWS));
        for (int i = 0; i < wr_cyc_q.size() && i < exp_cyc.size(); i++) begin
            check_eq($sformatf("wr%0d_cyc", i), 64'(wr_cyc_q[i]), 64'(exp_cyc[i]));
            check_eq($sformatf("wr%0d_addr", i), 64'(wr_addr_q[i]), 64'(exp_addr[i]));
            check_eq($sformatf("wr%0d_data", i), 64'(wr_data_q[i]), 64'(exp_data[i]));
        end
        check_eq("n_done", 64'(done_cyc_q.size()), 64'd1);
        if (done_cyc_q.size() > 0) check_eq("done_cyc", 64'(done_cyc_q[0]), 64'(exp_done));
        check_eq("overflow", 64'(overflow), 64'(exp_ovf));
        check_eq("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [WS-1:0] relu_exp;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        col_valid = '0;
        matmul_output = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_addr", 64'(mem_addr), 64'd0);
        check_eq("reset_wren", 64'(mem_wr_en), 64'd0);
        check_eq("reset_data", 64'(mem_wr_data), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(wr_done), 64'd0);
        check_eq("reset_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_nominal();
        run_stream(-1, 0, 1'b0, -1, 1'b0);
        set_nominal();
        run_stream(3, 2, 1'b0, -1, 1'b0);
        set_nominal();
        run_stream(-1, 0, 1'b0, 2, 1'b0);
        set_nominal();
        run_stream(-1, 0, 1'b1, -1, 1'b0);

        set_nominal();
        vals[2][1] = 16'hFFF0;
`ifdef RESULT_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF0;
`endif
        run_stream(-1, 0, 1'b0, -1, 1'b0);
        if (wr_data_q.size() > 2) check_eq("relu_elem", 64'(wr_data_q[2][WS +: WS]), 64'(relu_exp));

        set_nominal();
        run_stream(-1, 0, 1'b0, -1, 1'b1);
        set_nominal();
        run_stream(-1, 0, 1'b0, -1, 1'b0);

        for (int it = 0; it < 8; it++) begin
            set_random();
            run_stream($urandom_range(0, 10), $urandom_range(0, 3), 1'b0, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_result_writer.md
# systolic_result_writer

Write-back engine for the weight-stationary systolic datapath. It is the writer counterpart of the matmul FSM's read path. It captures the skewed per-column `matmul_output` stream qualified by `output_col_valid`, deskews it into full result rows, and writes each row to RAM at `RESULT_BASE_ADDR` through the same latency-bounded single-port memory protocol the FSM uses for reads. It sits between the systolic bottom outputs and the RAM write port, and signals completion when all `ROWS` result rows are committed.

## Interface
- `ROWS`, 4, systolic rows; also the number of result rows per matmul
- `COLS`, 4, systolic columns; elements per result row
- `WORD_SIZE`, 16, signed element width
- `MEM_ACCESS_LATENCY`, 2, cycles the RAM port is occupied per write (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; arms a new collection
- `stall`  in  1  FSM stall; samples on stalled cycles are ignored
- `matmul_output`  in  COLS*WORD_SIZE  systolic bottom_out; column c at `[c*WORD_SIZE +: WORD_SIZE]`
- `output_col_valid`  in  COLS  per-column valid
- `mem_addr`  out  32  write address
- `mem_wr_en`  out  1  write strobe, one cycle per row
- `mem_wr_data`  out  `MEM_PORT_WIDTH`  row data, column c at `[c*WORD_SIZE +: WORD_SIZE]`
- `busy`  out  1  armed and not yet done
- `wr_done`  out  1  one-cycle pulse after the last row write completes
- `overflow`  out  1  sticky; a column received more than `ROWS` samples

## Operation
- Capture: on each cycle with `output_col_valid[c] && !stall && busy`, store `matmul_output` column c into `row_buf[col_cnt[c]][c]`, then increment `col_cnt[c]`.
- If `col_cnt[c] == ROWS` at capture time, drop the sample and set `overflow`.
- Row completion: a capture into column `COLS-1` completes row `col_cnt[COLS-1]`. That row index is pushed into the row FIFO (depth `ROWS`) on the same edge.
- Writer FSM:
  - W_IDLE: if the FIFO is non-empty, pop row r and go to W_ISSUE.
  - W_ISSUE: `mem_wr_en=1`, `mem_addr = RESULT_BASE_ADDR + r*MEM_ADDR_INCR`, `mem_wr_data = row_buf[r]`. Then set `wait_cnt = MEM_ACCESS_LATENCY-1` and go to W_WAIT, or go straight to W_IDLE if that value is 0.
  - W_WAIT: decrement `wait_cnt`; go to W_IDLE when it reaches 0.
- Completion: the write counter reaches `ROWS` once the final W_WAIT/W_ISSUE cycle retires. Then pulse `wr_done`, clear `busy`, and clear `col_cnt`.
- `start` while `busy`: ignored.
- `start` while idle: clears counters, FIFO and `overflow`, and sets `busy`.
- A FIFO push and pop in the same cycle are both honoured. The FIFO cannot overflow, because each row index is pushed exactly once.
- Arithmetic: counters are `$clog2(ROWS)+1` bits wide. Addresses are computed in 32 bits with no wrap.

## Timing
- Reset values: `mem_addr=0`, `mem_wr_en=0`, `mem_wr_data=0`, `busy=0`, `wr_done=0`, `overflow=0`. The writer FSM is in W_IDLE and all counters are 0.
- Reset mid-operation discards all buffered rows. No partial write strobe follows reset release.
- Latency:
  - Row r's last-column capture edge leads to `mem_wr_en` for r two edges later (push, then pop/issue) when the writer is idle.
  - Back-to-back rows are spaced `MEM_ACCESS_LATENCY` cycles apart.
- Capture during an active write is permitted. Capture never waits on memory.
- `wr_done` asserts the cycle after the last write's occupancy ends.
- `overflow` holds until the next accepted `start`.

## Configuration
- `RESULT_RELU_EN`:
  - Defined: each element is clamped to 0 if negative (signed `WORD_SIZE`) when it is written into `row_buf`.
  - Undefined: elements are stored unmodified.
- Timing is identical in both builds.

## Structure
- Shared package `systolic_pkg`:
  - writer state enum (`W_IDLE`, `W_ISSUE`, `W_WAIT`)
  - `RESULT_BASE_ADDR`, `MEM_ADDR_INCR`, `MEM_PORT_WIDTH` constants, shared with the matmul FSM's base addresses
- One sub-module: `result_row_fifo`, a synchronous FIFO of row indices with depth `ROWS` and push/pop/empty. The row data stays in `row_buf`.

## Test plan
(ROWS=COLS=4, WORD_SIZE=16, L=2)
- Nominal: start, then skewed stream (column c valid cycles c..c+3, value 16r+c). Required: 4 writes at `RESULT_BASE_ADDR + {0,1,2,3}*MEM_ADDR_INCR` with data {3,2,1,0}+16r per row. Writes are 2 cycles apart, followed by one `wr_done` pulse.
- Stall: the same stream with `stall=1` for 2 cycles mid-stream while valids hold. Required: stalled samples are ignored and the written data is identical to the nominal case.
- Reset mid-write: assert `rst_n=0` during W_WAIT of row 1. Required: all outputs are 0 and no further `mem_wr_en` appears; a new start and stream then produce 4 correct writes.
- Overflow: a fifth valid sample on column 0. Required: `overflow=1`, row 0 data unchanged, `wr_done` still occurs after 4 writes.
- ReLU: with `RESULT_RELU_EN`, value 16'hFFF0 in row 2 column 1 is written as 0; without the macro it is written as 16'hFFF0.
- Start while busy: a second `start` pulse mid-stream is ignored and exactly 4 writes occur.
